mem_access_unit: RTL and testbench

- MEM-stage load/store unit sitting between the EX/MEM pipeline register and the byte-addressed data RAM.
- Drives the RAM's word port with a word-aligned address, per-byte write enables and lane-replicated write data.
- Extracts and sign- or zero-extends load results for LB/LH/LW/LBU/LHU.
- Splits accesses that cross a word boundary into two back-to-back aligned accesses, stalling the pipeline for one cycle; results are registered toward MEM/WB.

---
 rtl/mem_access_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane steering, load extension, and two-cycle split of word-crossing accesses.
// Build option: `define MISALIGN_TRAP_EN replaces splitting with a registered misalign_err response.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 9,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_func3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic                  dmem_we,
  output logic [3:0]            dmem_be,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  misalign_err
`endif
);

  localparam logic IDLE  = 1'b0;
  localparam logic SPLIT = 1'b1;

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = 4'd1;
      2'b01:   size_of = 4'd2;
      default: size_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
    is_misaligned = ({2'b00, off} + size_of(f3)) > 4'd4;
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [XLEN-1:0] wd, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  // raw holds the addressed byte/half already shifted down to lane 0
  function automatic logic signed [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                         input logic [2:0]      f3);
    case (f3[1:0])
      2'b00:   extend_load = f3[2] ? $signed({{(XLEN-8){1'b0}}, raw[7:0]})
                                   : $signed({{(XLEN-8){raw[7]}}, raw[7:0]});
      2'b01:   extend_load = f3[2] ? $signed({{(XLEN-16){1'b0}}, raw[15:0]})
                                   : $signed({{(XLEN-16){raw[15]}}, raw[15:0]});
      default: extend_load = $signed(raw);
    endcase
  endfunction

  logic [1:0]      off_p0;
  logic [3:0]      be_p0;
  logic            mis_p0;
  logic            vld_p0;
  logic [XLEN-1:0] rdata_p0;

  assign off_p0 = req_addr[1:0];
  assign be_p0  = lane_mask(req_func3) << off_p0;
  assign mis_p0 = is_misaligned(off_p0, req_func3);

`ifdef MISALIGN_TRAP_EN
  logic err_p0;

  always_comb begin
    stall      = 1'b0;
    dmem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = store_lanes(req_wdata, req_func3);
    vld_p0     = 1'b0;
    rdata_p0   = '0;
    err_p0     = 1'b0;
    if (req_valid) begin
      vld_p0 = 1'b1;
      if (mis_p0) begin
        err_p0 = 1'b1;
      end else begin
        dmem_we  = req_we;
        dmem_be  = req_we ? be_p0 : 4'b0000;
        rdata_p0 = req_we ? '0 : extend_load(dmem_rdata >> {off_p0, 3'b000}, req_func3);
      end
    end
    if (!rst_n) begin
      dmem_we = 1'b0;
      dmem_be = 4'b0000;
    end
  end

  // ---- stage 1: MEM/WB response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      misalign_err <= 1'b0;
    end else begin
      resp_valid   <= vld_p0;
      resp_rdata   <= rdata_p0;
      misalign_err <= err_p0;
    end
  end
`else
  logic                  state;
  logic                  state_nxt;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [2:0]            func3_p1;
  logic [XLEN-1:0]       wdata_p1;
  logic                  we_p1;
  logic [XLEN-1:0]       lo_p1;
  logic [1:0]            off_p1;
  logic [2:0]            hi_sh;
  logic [ADDR_WIDTH-3:0] hi_word;
  logic [XLEN-1:0]       merged;

  assign off_p1  = addr_p1[1:0];
  assign hi_sh   = 3'd4 - {1'b0, off_p1};
  assign hi_word = addr_p1[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1);
  // low bytes from the captured first word, upper bytes from the word now on the bus
  assign merged  = (lo_p1 >> {off_p1, 3'b000}) | (dmem_rdata << {hi_sh, 3'b000});

  always_comb begin
    state_nxt  = IDLE;
    capture    = 1'b0;
    stall      = 1'b0;
    dmem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = store_lanes(req_wdata, req_func3);
    vld_p0     = 1'b0;
    rdata_p0   = '0;
    if (state == SPLIT) begin
      dmem_addr  = {hi_word, 2'b00};
      dmem_we    = we_p1;
      dmem_be    = we_p1 ? (lane_mask(func3_p1) >> hi_sh) : 4'b0000;
      dmem_wdata = wdata_p1 >> {hi_sh, 3'b000};
      vld_p0     = 1'b1;
      rdata_p0   = we_p1 ? '0 : extend_load(merged, func3_p1);
    end else if (req_valid) begin
      dmem_we = req_we;
      dmem_be = req_we ? be_p0 : 4'b0000;
      if (mis_p0) begin
        stall      = 1'b1;
        capture    = 1'b1;
        state_nxt  = SPLIT;
        dmem_wdata = req_wdata << {off_p0, 3'b000};
      end else begin
        vld_p0   = 1'b1;
        rdata_p0 = req_we ? '0 : extend_load(dmem_rdata >> {off_p0, 3'b000}, req_func3);
      end
    end
    if (!rst_n) begin
      stall   = 1'b0;
      dmem_we = 1'b0;
      dmem_be = 4'b0000;
    end
  end

  // ---- stage 1: split capture and MEM/WB response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_p1    <= '0;
      func3_p1   <= '0;
      wdata_p1   <= '0;
      we_p1      <= 1'b0;
      lo_p1      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        addr_p1  <= req_addr;
        func3_p1 <= req_func3;
        wdata_p1 <= req_wdata;
        we_p1    <= req_we;
        lo_p1    <= dmem_rdata;
      end
      resp_valid <= vld_p0;
      resp_rdata <= rdata_p0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural byte-enabled word RAM.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [8:0]  dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:127];
  logic        pre_en;
  logic [6:0]  pre_idx;
  logic [31:0] pre_data;

  mem_access_unit #(.ADDR_WIDTH(9), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dmem_rdata = mem[dmem_addr[8:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (dmem_we)
      for (int i = 0; i < 4; i++)
        if (dmem_be[i]) mem[dmem_addr[8:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [6:0] idx, input logic [31:0] data);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    step();
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000; req_addr = '0; req_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue(1'b1, 3'b010, 9'h010, 32'h12345678);
    step(); step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", dmem_we); end
    checks++; if (dmem_be !== 4'b0000) begin errors++; $display("FAIL reset_be: got %b expected 0000", dmem_be); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 00000000", resp_rdata); end
    idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_aligned_lw();
    preload(7'd4, 32'h8899AABB);
    issue(1'b0, 3'b010, 9'h010, 32'h0);
    checks++; if (dmem_addr !== 9'h010) begin errors++; $display("FAIL lw_addr: got %h expected 010", dmem_addr); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_stall: got %b expected 0", stall); end
    checks++; if (dmem_be !== 4'b0000) begin errors++; $display("FAIL lw_be: got %b expected 0000", dmem_be); end
    step();
    idle();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lw_resp_valid: got %b expected 1", resp_valid); end
    checks++; if (resp_rdata !== 32'h8899AABB) begin errors++; $display("FAIL lw_rdata: got %h expected 8899aabb", resp_rdata); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp_valid: got %b expected 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 3'b000, 9'h013, 32'h000000EE);
    checks++; if (dmem_addr !== 9'h010) begin errors++; $display("FAIL sb_addr: got %h expected 010", dmem_addr); end
    checks++; if (dmem_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", dmem_be); end
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b expected 1", dmem_we); end
    checks++; if (dmem_wdata !== 32'hEEEEEEEE) begin errors++; $display("FAIL sb_wdata: got %h expected eeeeeeee", dmem_wdata); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL sb_resp: got %b/%h expected 1/00000000", resp_valid, resp_rdata); end
    issue(1'b0, 3'b000, 9'h013, 32'h0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_stall: got %b expected 0", stall); end
    step();
    checks++; if (resp_rdata !== 32'hFFFFFFEE) begin errors++; $display("FAIL lb_rdata: got %h expected ffffffee", resp_rdata); end
    issue(1'b0, 3'b100, 9'h013, 32'h0);
    step();
    checks++; if (resp_rdata !== 32'h000000EE) begin errors++; $display("FAIL lbu_rdata: got %h expected 000000ee", resp_rdata); end
    issue(1'b0, 3'b101, 9'h012, 32'h0);
    step();
    idle();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000EE99) begin errors++; $display("FAIL lhu_rdata: got %b/%h expected 1/0000ee99", resp_valid, resp_rdata); end
    step();
  endtask

`ifndef MISALIGN_TRAP_EN
  task automatic test_split_lw();
    preload(7'd3, 32'h44332211);
    preload(7'd4, 32'h88776655);
    issue(1'b0, 3'b010, 9'h00E, 32'h0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL slw_stall_n: got %b expected 1", stall); end
    checks++; if (dmem_addr !== 9'h00C) begin errors++; $display("FAIL slw_addr_n: got %h expected 00c", dmem_addr); end
    step();
    // upstream changes its inputs; the split must keep using the captured request
    issue(1'b1, 3'b010, 9'h000, 32'hDEADBEEF);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL slw_resp_n1: got %b expected 0", resp_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL slw_stall_n1: got %b expected 0", stall); end
    checks++; if (dmem_addr !== 9'h010) begin errors++; $display("FAIL slw_addr_n1: got %h expected 010", dmem_addr); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL slw_we_n1: got %b expected 0", dmem_we); end
    step();
    idle();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h66554433) begin errors++; $display("FAIL slw_rdata: got %b/%h expected 1/66554433", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_split_sh();
    preload(7'd2, 32'h00000000);
    issue(1'b1, 3'b001, 9'h00B, 32'h0000BEEF);
    checks++; if (stall !== 1'b1 || dmem_addr !== 9'h008 || dmem_be !== 4'b1000) begin errors++; $display("FAIL ssh_low: got stall=%b addr=%h be=%b expected 1/008/1000", stall, dmem_addr, dmem_be); end
    checks++; if (dmem_wdata[31:24] !== 8'hEF) begin errors++; $display("FAIL ssh_low_byte: got %h expected ef", dmem_wdata[31:24]); end
    step();
    checks++; if (stall !== 1'b0 || dmem_addr !== 9'h00C || dmem_be !== 4'b0001 || dmem_we !== 1'b1) begin errors++; $display("FAIL ssh_high: got stall=%b addr=%h be=%b we=%b expected 0/00c/0001/1", stall, dmem_addr, dmem_be, dmem_we); end
    checks++; if (dmem_wdata[7:0] !== 8'hBE) begin errors++; $display("FAIL ssh_high_byte: got %h expected be", dmem_wdata[7:0]); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL ssh_resp: got %b/%h expected 1/00000000", resp_valid, resp_rdata); end
    checks++; if (mem[2] !== 32'hEF000000 || mem[3] !== 32'h443322BE) begin errors++; $display("FAIL ssh_ram: got %h %h expected ef000000 443322be", mem[2], mem[3]); end
    issue(1'b0, 3'b001, 9'h00B, 32'h0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lh_after_split_stall: got %b expected 1", stall); end
    step();
    step();
    idle();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_split_rdata: got %b/%h expected 1/ffffbeef", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_wrap();
    issue(1'b1, 3'b010, 9'h1FE, 32'hCAFEF00D);
    checks++; if (dmem_addr !== 9'h1FC || dmem_be !== 4'b1100 || dmem_wdata[31:16] !== 16'hF00D) begin errors++; $display("FAIL wrap_low: got addr=%h be=%b hi16=%h expected 1fc/1100/f00d", dmem_addr, dmem_be, dmem_wdata[31:16]); end
    step();
    checks++; if (dmem_addr !== 9'h000 || dmem_be !== 4'b0011) begin errors++; $display("FAIL wrap_high: got addr=%h be=%b expected 000/0011", dmem_addr, dmem_be); end
    checks++; if (dmem_wdata[15:0] !== 16'hCAFE) begin errors++; $display("FAIL wrap_high_data: got %h expected cafe", dmem_wdata[15:0]); end
    step();
    idle();
    checks++; if (mem[0][15:0] !== 16'hCAFE || mem[127][31:16] !== 16'hF00D) begin errors++; $display("FAIL wrap_ram: got %h %h expected cafe f00d", mem[0][15:0], mem[127][31:16]); end
    step();
  endtask

  task automatic test_reset_mid_split();
    preload(7'd5, 32'hA5A5A5A5);
    issue(1'b1, 3'b010, 9'h011, 32'h11223344);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_stall: got %b expected 1", stall); end
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'b0000) begin errors++; $display("FAIL rms_outputs: got stall=%b we=%b be=%b expected 0/0/0000", stall, dmem_we, dmem_be); end
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL rms_resp: got %b/%h expected 0/00000000", resp_valid, resp_rdata); end
    step();
    checks++; if (mem[5] !== 32'hA5A5A5A5) begin errors++; $display("FAIL rms_high_word: got %h expected a5a5a5a5", mem[5]); end
    idle();
    rst_n = 1'b1;
    step();
    issue(1'b0, 3'b010, 9'h014, 32'h0);
    checks++; if (stall !== 1'b0 || dmem_addr !== 9'h014) begin errors++; $display("FAIL rms_next_req: got stall=%b addr=%h expected 0/014", stall, dmem_addr); end
    step();
    idle();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rms_next_resp: got %b/%h expected 1/a5a5a5a5", resp_valid, resp_rdata); end
    step();
  endtask
`else
  task automatic test_trap();
    issue(1'b0, 3'b010, 9'h00E, 32'h0);
    checks++; if (stall !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'b0000) begin errors++; $display("FAIL trap_access: got stall=%b we=%b be=%b expected 0/0/0000", stall, dmem_we, dmem_be); end
    step();
    idle();
    checks++; if (misalign_err !== 1'b1 || resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL trap_resp: got err=%b vld=%b rdata=%h expected 1/1/00000000", misalign_err, resp_valid, resp_rdata); end
    step();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL trap_pulse: got %b expected 0", misalign_err); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    idle();
    test_reset();
    test_aligned_lw();
    test_back_to_back();
`ifndef MISALIGN_TRAP_EN
    test_split_lw();
    test_split_sh();
    test_wrap();
    test_reset_mid_split();
`else
    test_trap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
